bus_serial_rx: RTL
==================

Name: bus_serial_rx

Overview:
- Target-side end of the serial bus link: receives request frames over SERIAL_WIDTH lanes, deserializes them into one parallel OCP-style bus request (MCmd/MAddr/MData/MByteEn), and waits for the slave response.
- Serializes that response back over a separate lane group.
- Sits between the serial link and a bus target (memory or IO block); pairs with the initiator-side serializer.

Parameters:
- SERIAL_WIDTH, 4, lanes per beat in each direction; ADDR_WIDTH and DATA_WIDTH must be multiples of it.
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width; byte enable width BE_W = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, response timeout; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ser_req_valid  in  1  request beat valid.
- ser_req_data  in  SERIAL_WIDTH  request beat.
- ser_req_ready  out  1  request beat accepted when valid&&ready.
- ser_resp_valid  out  1  response beat valid.
- ser_resp_data  out  SERIAL_WIDTH  response beat.
- ser_resp_ready  in  1  response beat consumed when valid&&ready.
- MCmd  out  3  0 idle, 1 write, 2 read.
- MAddr  out  ADDR_WIDTH  request address.
- MData  out  DATA_WIDTH  write data.
- MByteEn  out  BE_W  byte enables.
- SCmdAccept  in  1  slave accepts command.
- SResp  in  2  0 none, 1 DVA, 2 FAIL, 3 ERR.
- SData  in  DATA_WIDTH  read data, valid with SResp!=0.

Behaviour:
- Beat counts: AB=ADDR_WIDTH/SERIAL_WIDTH, BB=ceil(BE_W/SERIAL_WIDTH), DB=DATA_WIDTH/SERIAL_WIDTH. All multi-beat fields are sent LSB beat first. Pad bits in the last BE beat are ignored.
- Request frame:
  - Header beat: bits[1:0]=cmd, 1 write, 2 read.
  - Then AB address beats, then BB byte-enable beats.
  - Then DB data beats, for writes only.
- Response frame:
  - Header beat: bits[1:0]=SResp code.
  - Then DB data beats, for reads with DVA only.
- States and transitions:
  - IDLE: consumes the header beat. cmd 1 or 2 -> ADDR. cmd 0 or 3 -> beat dropped, remain IDLE.
  - ADDR -> BE -> DATA (write) or ISSUE (read); each field state advances after its last beat.
  - ISSUE: drives MCmd with registered MAddr/MData/MByteEn, holding all values stable until SCmdAccept. On the accept cycle -> WAIT. If SResp!=0 arrives in that same cycle, it is captured and the block goes straight to RESP.
  - WAIT: captures SResp/SData on the first cycle SResp!=0 -> RESP.
  - RESP: presents beats in order. Each beat is held until ser_resp_ready; the next beat follows the cycle after acceptance. After the last beat -> IDLE.
- ser_req_ready=1 only in IDLE, ADDR, BE and DATA; 0 in ISSUE, WAIT and RESP, so only one transaction is outstanding.
- A beat counter resets on every field transition. It is sized for max(AB,BB,DB) and never wraps within a field.
- MCmd=0 in every state except ISSUE. MAddr/MData/MByteEn hold their last values outside ISSUE.
- SResp!=0 while in IDLE or ISSUE-before-accept is ignored.
- Latency: MCmd asserts the cycle after the last request beat is accepted. ser_resp_valid asserts the cycle after SResp is captured.
- Reset (asynchronous, any state including mid-frame):
  - state=IDLE, counters=0.
  - MCmd=0, MAddr=0, MData=0, MByteEn=0.
  - ser_req_ready=0 while reset is asserted, 1 the first cycle after release.
  - ser_resp_valid=0, ser_resp_data=0.
  - Partial frames are discarded; no bus command is issued for them.

Optional Feature:
- Macro: BUS_SERIAL_RX_TIMEOUT_EN.
- Defined: a counter runs in ISSUE and WAIT and clears on every state entry. When it reaches TIMEOUT_CYCLES:
  - MCmd is forced to 0.
  - The block enters RESP with header ERR (3) and no data beats, even for reads.
  - Any SResp arriving later is ignored until the next ISSUE.
- Undefined: no counter; the block waits indefinitely in ISSUE/WAIT.

Test Plan:
- Write addr 123, data 0xdeadface, BE 0xf (SERIAL_WIDTH=4: 1+8+1+8 beats), memory target with 1-cycle response -> MCmd=1, MAddr=123, MData=0xdeadface, MByteEn=0xf for exactly one accepted cycle; response frame is single header beat 0x1.
- Read addr 123 after that write -> MCmd=2; response frame is header 0x1 then 8 beats 0xe,0xc,0xa,0xf,0xd,0xa,0xe,0xd.
- Header beat cmd=0 and cmd=3, then a valid read -> no MCmd for the invalid headers; read completes normally.
- ser_resp_ready held low 5 cycles mid read-response -> current beat value and ser_resp_valid stable for those 5 cycles; no beat lost or duplicated; ser_req_ready stays 0 until the final beat is accepted.
- reset pulse after 4 address beats of a write, then a full read of addr 0 -> no MCmd=1 ever issued; read returns the memory's value at addr 0.
- With BUS_SERIAL_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16, SCmdAccept tied 0 -> MCmd drops to 0 after 16 ISSUE cycles; response frame is single header beat 0x3.

Source files
------------

// File: rtl/bus_serial_rx.sv
// Target-side serial bus receiver: deserializes request frames into one OCP-style
// bus command, then serializes the slave response. Optional timeout: BUS_SERIAL_RX_TIMEOUT_EN.
module bus_serial_rx #(
  parameter int SERIAL_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ser_req_valid,
  input  logic [SERIAL_WIDTH-1:0]   ser_req_data,
  output logic                      ser_req_ready,
  output logic                      ser_resp_valid,
  output logic [SERIAL_WIDTH-1:0]   ser_resp_data,
  input  logic                      ser_resp_ready,
  output logic [2:0]                MCmd,
  output logic [ADDR_WIDTH-1:0]     MAddr,
  output logic [DATA_WIDTH-1:0]     MData,
  output logic [DATA_WIDTH/8-1:0]   MByteEn,
  input  logic                      SCmdAccept,
  input  logic [1:0]                SResp,
  input  logic [DATA_WIDTH-1:0]     SData
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int AB   = ADDR_WIDTH / SERIAL_WIDTH;
  localparam int BB   = (BE_W + SERIAL_WIDTH - 1) / SERIAL_WIDTH;
  localparam int DB   = DATA_WIDTH / SERIAL_WIDTH;
  localparam int BSW  = BB * SERIAL_WIDTH;
  localparam int MAXB = (AB > BB) ? ((AB > DB) ? AB : DB) : ((BB > DB) ? BB : DB);
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BE, S_DATA, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0] cmd_reg;
  logic [ADDR_WIDTH-1:0] addr_sh_reg, maddr_reg;
  logic [BSW-1:0] be_sh_reg;
  logic [BE_W-1:0] mbe_reg;
  logic [DATA_WIDTH-1:0] data_sh_reg, mdata_reg, rdata_reg;
  logic [1:0] rcode_reg;
  logic rhas_data_reg;

  logic req_fire, resp_fire, resp_last;
  logic load_bus, capture, timeout_fire, timeout_hit;

  // Each field is shifted in from the top so the first (LSB) beat ends up at bit 0.
  logic [ADDR_WIDTH+SERIAL_WIDTH-1:0] addr_cat;
  logic [BSW+SERIAL_WIDTH-1:0] be_cat;
  logic [DATA_WIDTH+SERIAL_WIDTH-1:0] data_cat;
  logic [ADDR_WIDTH-1:0] addr_shifted;
  logic [BSW-1:0] be_shifted;
  logic [DATA_WIDTH-1:0] data_shifted;

  assign addr_cat     = {ser_req_data, addr_sh_reg};
  assign be_cat       = {ser_req_data, be_sh_reg};
  assign data_cat     = {ser_req_data, data_sh_reg};
  assign addr_shifted = addr_cat[ADDR_WIDTH+SERIAL_WIDTH-1:SERIAL_WIDTH];
  assign be_shifted   = be_cat[BSW+SERIAL_WIDTH-1:SERIAL_WIDTH];
  assign data_shifted = data_cat[DATA_WIDTH+SERIAL_WIDTH-1:SERIAL_WIDTH];

  assign ser_req_ready  = !reset && (state_reg == S_IDLE || state_reg == S_ADDR ||
                                     state_reg == S_BE   || state_reg == S_DATA);
  assign ser_resp_valid = (state_reg == S_RESP);
  assign req_fire       = ser_req_valid && ser_req_ready;
  assign resp_fire      = ser_resp_valid && ser_resp_ready;
  assign resp_last      = rhas_data_reg ? (cnt_reg == CW'(DB)) : (cnt_reg == '0);

  // Beat 0 of the response is the header; data beats are drained from rdata_reg's LSBs.
  assign ser_resp_data = (state_reg != S_RESP) ? '0 :
                         (cnt_reg == '0) ? SERIAL_WIDTH'(rcode_reg) :
                         rdata_reg[SERIAL_WIDTH-1:0];

  assign MCmd    = (state_reg == S_ISSUE) ? {1'b0, cmd_reg} : 3'd0;
  assign MAddr   = maddr_reg;
  assign MData   = mdata_reg;
  assign MByteEn = mbe_reg;

`ifdef BUS_SERIAL_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_reg <= '0;
    end else if ((state_reg == S_ISSUE || state_reg == S_WAIT) && state_next == state_reg) begin
      tcnt_reg <= tcnt_reg + TW'(1);
    end else begin
      tcnt_reg <= '0;
    end
  end

  assign timeout_hit = (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    load_bus     = 1'b0;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_fire && (ser_req_data[1:0] == 2'd1 || ser_req_data[1:0] == 2'd2)) begin
          state_next = S_ADDR;
          cnt_next   = '0;
        end
      end
      S_ADDR: begin
        if (req_fire) begin
          if (cnt_reg == CW'(AB - 1)) begin
            state_next = S_BE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      S_BE: begin
        if (req_fire) begin
          if (cnt_reg == CW'(BB - 1)) begin
            cnt_next = '0;
            if (cmd_reg == 2'd1) begin
              state_next = S_DATA;
            end else begin
              state_next = S_ISSUE;
              load_bus   = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (req_fire) begin
          if (cnt_reg == CW'(DB - 1)) begin
            state_next = S_ISSUE;
            cnt_next   = '0;
            load_bus   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      S_ISSUE: begin
        if (SCmdAccept) begin
          if (SResp != 2'd0) begin
            capture    = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = S_RESP;
        end
      end
      S_WAIT: begin
        if (SResp != 2'd0) begin
          capture    = 1'b1;
          state_next = S_RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          if (resp_last) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_reg       <= 2'd0;
      addr_sh_reg   <= '0;
      be_sh_reg     <= '0;
      data_sh_reg   <= '0;
      maddr_reg     <= '0;
      mdata_reg     <= '0;
      mbe_reg       <= '0;
      rdata_reg     <= '0;
      rcode_reg     <= 2'd0;
      rhas_data_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && state_next == S_ADDR) begin
        cmd_reg <= ser_req_data[1:0];
      end
      if (req_fire) begin
        case (state_reg)
          S_ADDR:  addr_sh_reg <= addr_shifted;
          S_BE:    be_sh_reg   <= be_shifted;
          S_DATA:  data_sh_reg <= data_shifted;
          default: ;
        endcase
      end
      // The last request beat lands in the same cycle the bus registers load.
      if (load_bus) begin
        maddr_reg <= addr_sh_reg;
        mbe_reg   <= (state_reg == S_BE) ? be_shifted[BE_W-1:0] : be_sh_reg[BE_W-1:0];
        if (cmd_reg == 2'd1) begin
          mdata_reg <= data_shifted;
        end
      end
      if (capture) begin
        rcode_reg     <= SResp;
        rdata_reg     <= SData;
        rhas_data_reg <= (cmd_reg == 2'd2) && (SResp == 2'd1);
      end else if (timeout_fire) begin
        rcode_reg     <= 2'd3;
        rhas_data_reg <= 1'b0;
      end else if (resp_fire && cnt_reg != '0) begin
        rdata_reg <= rdata_reg >> SERIAL_WIDTH;
      end
    end
  end

endmodule
